// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit: state encoding,
// output-slot payload and the reset PC.
package fetch_pc_unit_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u1 ON  = 1'b1;
    localparam u1 OFF = 1'b0;

    localparam u64 PC_RESET = 64'h0000_0000_8000_0000;
    localparam u64 PC_STEP  = 64'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        u64 pc;
        u32 instr;
        u1  exc;
    } fetch_out_t;

    function automatic u1 pc_aligned(input u64 pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Fetch/decode output slot: holds one {pc, instr, exc} entry under a
// valid/ready handshake; flush empties it without delivering the entry.
module fetch_out_reg
    import fetch_pc_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  fetch_out_t load_data,
    input  logic       flush,
    input  logic       ready,
    output logic       valid,
    output fetch_out_t data
);

    // Payload only changes on load, so it stays stable while decode stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= OFF;
            data  <= '0;
        end else if (flush) begin
            valid <= OFF;
        end else if (load) begin
            valid <= ON;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= OFF;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register and instruction-bus front end. One bus request at
// a time; redirects during an in-flight request drain the stale response.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter u64 RESET_PC = PC_RESET
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic         ireq_valid,
    output logic [63:0]  ireq_addr,
    input  logic         iresp_ok,
    input  logic [31:0]  iresp_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_pc,
    output logic [31:0]  out_instr,
    output logic         out_exc,
    output fetch_state_t fsm_state
);

    fetch_state_t state, state_next;
    u64           pc, pc_next;
    u64           pend_pc, pend_next;
    logic         slot_load, slot_flush;
    fetch_out_t   slot_data, slot_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else begin
            pc      <= pc_next;
            pend_pc <= pend_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        pend_next  = pend_pc;
        slot_load  = OFF;
        slot_flush = OFF;
        slot_data  = '{pc: pc, instr: iresp_data, exc: OFF};
        unique case (state)
            FETCH: begin
                if (pc_aligned(pc)) begin
                    if (iresp_ok && !redirect_valid) begin
                        slot_load  = ON;
                        pc_next    = pc + PC_STEP;
                        state_next = HOLD;
                    end else if (iresp_ok) begin
                        pc_next = redirect_pc;
                    end else if (redirect_valid) begin
                        pend_next  = redirect_pc;
                        state_next = DRAIN;
                    end
                end else if (redirect_valid) begin
                    pc_next = redirect_pc;
                end else begin
                    // Misaligned PC never reaches the bus; report it as an exception entry.
                    slot_load  = ON;
                    slot_data  = '{pc: pc, instr: 32'h0, exc: ON};
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    slot_flush = ON;
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (out_ready) begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                // The bus must see the stale request through; only the newest target survives.
                if (iresp_ok) begin
                    pc_next    = redirect_valid ? redirect_pc : pend_pc;
                    state_next = FETCH;
                end else if (redirect_valid) begin
                    pend_next = redirect_pc;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        ireq_valid = reset_n && ((state == DRAIN) || ((state == FETCH) && pc_aligned(pc)));
        ireq_addr  = pc;
        fsm_state  = state;
    end

    fetch_out_reg u_out_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (slot_load),
        .load_data (slot_data),
        .flush     (slot_flush),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (slot_q)
    );

    assign out_pc    = slot_q.pc;
    assign out_instr = slot_q.instr;
    assign out_exc   = slot_q.exc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random redirects, bus
// waits and decode stalls, scored against a stream-level reference model.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_pc = '0;
    logic         iresp_ok = 1'b0;
    logic [31:0]  iresp_data = '0;
    logic         out_ready = 1'b0;
    logic         ireq_valid;
    logic [63:0]  ireq_addr;
    logic         out_valid;
    logic [63:0]  out_pc;
    logic [31:0]  out_instr;
    logic         out_exc;
    fetch_state_t fsm_state;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_ok       (iresp_ok),
        .iresp_data     (iresp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_exc        (out_exc),
        .fsm_state      (fsm_state)
    );

    int tests = 0;
    int fails = 0;
    logic [96:0] exp_q[$];

    // Reference model: architectural fetch pointer, pending redirect target,
    // whether the output slot is occupied and whether the in-flight response is doomed.
    logic [63:0] m_pc = RST_PC;
    logic [63:0] m_pend = '0;
    bit          m_slot = 1'b0;
    bit          m_discard = 1'b0;
    // Bus responder
    bit          req_active = 1'b0;
    int          wait_left = 0;
    int          wait_cfg = 0;

    task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a == RST_PC) ? 32'h0000_0013 : (a[31:0] ^ 32'hdead_0003);
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        m_pend = '0;
        m_slot = 1'b0;
        m_discard = 1'b0;
        req_active = 1'b0;
        wait_left = 0;
    endtask

    // One clock cycle: check request side, play the bus, drive inputs, advance the model.
    task automatic step(input logic rv, input logic [63:0] rpc, input logic rdy);
        bit           req, ok;
        logic [31:0]  d;
        fetch_state_t es;
        req = !m_slot && (m_discard || (m_pc[1:0] == 2'b00));
        es  = m_slot ? HOLD : (m_discard ? DRAIN : FETCH);
        check("ireq_valid", ireq_valid, req);
        if (req) check("ireq_addr", ireq_addr, m_pc);
        check("fsm_state", fsm_state, es);

        if (req && !req_active) begin
            req_active = 1'b1;
            wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        end
        ok = req && (wait_left == 0);
        if (req && wait_left > 0) wait_left--;
        if (ok) req_active = 1'b0;
        d = ok ? mem_word(m_pc) : $urandom;

        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        iresp_ok       = ok;
        iresp_data     = d;

        if (m_slot) begin
            if (rv) begin
                m_slot = 1'b0;
                m_pc = rpc;
            end else if (rdy) begin
                m_slot = 1'b0;
            end
        end else if (m_discard) begin
            if (ok) begin
                m_pc = rv ? rpc : m_pend;
                m_discard = 1'b0;
            end else if (rv) begin
                m_pend = rpc;
            end
        end else if (m_pc[1:0] != 2'b00) begin
            if (rv) m_pc = rpc;
            else begin
                exp_q.push_back({m_pc, 32'h0, 1'b1});
                m_slot = 1'b1;
            end
        end else begin
            if (ok && !rv) begin
                exp_q.push_back({m_pc, d, 1'b0});
                m_pc = m_pc + 64'd4;
                m_slot = 1'b1;
            end else if (ok) begin
                m_pc = rpc;
            end else if (rv) begin
                m_pend = rpc;
                m_discard = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Advance to the first cycle of a fresh aligned request.
    task automatic step_to_req_start();
        int n = 0;
        while (!(!m_slot && !m_discard && (m_pc[1:0] == 2'b00) && !req_active) && n < 20) begin
            if (m_pc[1:0] != 2'b00) step(1'b1, 64'h0000_0000_8000_0800, 1'b1);
            else step(1'b0, '0, 1'b1);
            n++;
        end
        if (n >= 20) check("reach_req_start_timeout", n, 0);
    endtask

    // Monitor: each rising out_valid must match the next expected entry; held entries must not change.
    initial begin
        logic        pv;
        logic [96:0] last, cur;
        pv = 1'b0;
        last = '0;
        forever begin
            @(posedge clk);
            #2;
            cur = {out_pc, out_instr, out_exc};
            if (out_valid && !pv) begin
                if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
                else check("out_item", cur, exp_q.pop_front());
            end else if (out_valid && pv) begin
                check("out_stable", cur, last);
            end
            pv = out_valid;
            last = cur;
        end
    end

    initial begin
        model_reset();
        #12;
        check("rst_ireq_valid", ireq_valid, 1'b0);
        check("rst_ireq_addr", ireq_addr, RST_PC);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_exc", out_exc, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Zero-wait bus, decode always ready
        wait_cfg = 0;
        repeat (6) step(1'b0, '0, 1'b1);

        // Three wait cycles per request
        wait_cfg = 3;
        repeat (10) step(1'b0, '0, 1'b1);

        // Redirect in the first cycle of a slow request -> drain
        step_to_req_start();
        step(1'b1, 64'h0000_0000_8000_0100, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        // Two redirects while draining: newest wins
        step_to_req_start();
        step(1'b1, 64'h0000_0000_8000_0200, 1'b1);
        step(1'b1, 64'h0000_0000_8000_0300, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        // Decode stall in HOLD, then redirect during the stall
        wait_cfg = 0;
        step_to_req_start();
        step(1'b0, '0, 1'b0);
        repeat (5) step(1'b0, '0, 1'b0);
        step(1'b1, 64'h0000_0000_8000_0040, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1);

        // Misaligned redirect target
        step_to_req_start();
        step(1'b1, 64'h0000_0000_8000_0102, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 64'h0000_0000_8000_0400, 1'b1);

        // Random traffic
        wait_cfg = -1;
        for (int i = 0; i < 400; i++) begin
            logic [63:0] tgt;
            tgt = RST_PC + {52'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt = tgt + 64'd2;
            step(($urandom_range(0, 9) == 0), tgt, ($urandom_range(0, 3) != 0));
        end
        step(1'b1, 64'h0000_0000_8000_0500, 1'b1);

        // Reset while a request is outstanding
        wait_cfg = 3;
        step_to_req_start();
        step(1'b0, '0, 1'b1);
        #2;
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        iresp_ok = 1'b0;
        #1;
        check("midrst_ireq_valid", ireq_valid, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        wait_cfg = 0;
        repeat (6) step(1'b0, '0, 1'b1);

        @(posedge clk);
        #5;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
